// File: rtl/pc_sequencer.sv
// Purpose: owns the architectural PC and sequences one-at-a-time instruction
// fetch over a req/ack port. Each fetched word is handed to decode and held
// there while decode stalls. The next PC is pc+4, the npc unit's target, or
// the exception vector.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall                      decode cannot accept the held instruction
//   npc_valid/npc_src/npc      next-PC selection from the npc unit
//   exc_req                    external exception request (level)
//   imem_req/imem_addr         fetch request and address (stable until ack)
//   imem_ack/imem_rdata        fetch completion and fetched word
//   if_valid/if_instr/if_pc    instruction presented to decode
//   exc_taken/epc              exception-entry pulse and victim PC
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h8000_0180
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        npc_valid,
   input  logic [2:0]  npc_src,
   input  logic [31:0] npc,
   input  logic        exc_req,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        exc_taken,
   output logic [31:0] epc
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      ISSUED = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t            state, state_n;
   logic [XLEN-1:0]   pc, pc_n;
   logic              if_valid_n;
   logic [XLEN-1:0]   if_instr_n, if_pc_n, epc_n;
   logic              exc_taken_n;
   logic              imem_req_n;

   // Next-PC candidates for the instruction held in IF
   logic              take_npc_c;
   logic              npc_err_c;
   logic [XLEN-1:0]   target_c;
   logic              redirect_exc_c;

   assign take_npc_c     = npc_valid && !npc_src[2] && (npc_src[1:0] != 2'b00);
   assign npc_err_c      = npc_valid && npc_src[2];
   assign target_c       = take_npc_c ? npc : (if_pc + XLEN'(4));
   assign redirect_exc_c = exc_req || npc_err_c || (target_c[1:0] != 2'b00);

   // The PC register is the fetch address; it only moves once the
   // outstanding request has been acknowledged, so the address stays stable.
   assign imem_addr = pc;

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         if_valid  <= 1'b0;
         if_instr  <= '0;
         if_pc     <= '0;
         exc_taken <= 1'b0;
         epc       <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         imem_req  <= imem_req_n;
         if_valid  <= if_valid_n;
         if_instr  <= if_instr_n;
         if_pc     <= if_pc_n;
         exc_taken <= exc_taken_n;
         epc       <= epc_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      if_valid_n  = if_valid;
      if_instr_n  = if_instr;
      if_pc_n     = if_pc;
      epc_n       = epc;
      exc_taken_n = 1'b0;

      case (state)
         BOOT: begin
            state_n = FETCH;
         end

         FETCH: begin
            if (imem_ack) begin
               if (exc_req) begin
                  // Data arriving with an exception is dropped; refetch at vector
                  epc_n       = pc;
                  exc_taken_n = 1'b1;
                  pc_n        = EXC_VEC;
               end else begin
                  if_instr_n = imem_rdata;
                  if_pc_n    = pc;
                  if_valid_n = 1'b1;
                  state_n    = ISSUED;
               end
            end else if (exc_req) begin
               // Cannot withdraw the request; wait for its ack and discard it
               epc_n       = pc;
               exc_taken_n = 1'b1;
               state_n     = DRAIN;
            end
         end

         ISSUED: begin
            if (!stall) begin
               if_valid_n = 1'b0;
               state_n    = FETCH;
               if (redirect_exc_c) begin
                  pc_n        = EXC_VEC;
                  epc_n       = if_pc;
                  exc_taken_n = 1'b1;
               end else begin
                  pc_n = target_c;
               end
            end
         end

         DRAIN: begin
            if (imem_ack) begin
               pc_n    = EXC_VEC;
               state_n = FETCH;
            end
         end

         default: begin
            state_n = BOOT;
         end
      endcase

      imem_req_n = (state_n == FETCH) || (state_n == DRAIN);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC    = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, npc_valid, exc_req, imem_ack;
   logic [2:0]  npc_src;
   logic [31:0] npc, imem_rdata;
   logic        imem_req, if_valid, exc_taken;
   logic [31:0] imem_addr, if_instr, if_pc, epc;

   int checks = 0;
   int errors = 0;

   // Reference model: fetch/hold/exception bookkeeping at transaction level
   logic        m_boot, m_req, m_discard, m_hold, m_pulse;
   logic [31:0] m_addr, m_instr, m_ipc, m_epc;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .npc_valid(npc_valid),
      .npc_src(npc_src), .npc(npc), .exc_req(exc_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .exc_taken(exc_taken), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      stall = 0; npc_valid = 0; npc_src = 3'b000; npc = 32'h0;
      exc_req = 0; imem_ack = 0; imem_rdata = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic model_reset();
      m_boot = 1; m_req = 0; m_discard = 0; m_hold = 0; m_pulse = 0;
      m_addr = RST_PC; m_instr = 32'h0; m_ipc = 32'h0; m_epc = 32'h0;
   endtask

   task automatic model_step(input logic s, input logic nv, input logic [2:0] src,
                             input logic [31:0] tgt, input logic ex, input logic ak,
                             input logic [31:0] rd);
      logic [31:0] nxt;
      m_pulse = 0;
      if (m_boot) begin
         m_boot = 0;
         m_req  = 1;
      end else if (m_hold) begin
         if (!s) begin
            nxt = (nv && src >= 3'd1 && src <= 3'd3) ? tgt : m_ipc + 32'd4;
            m_hold = 0;
            m_req  = 1;
            if (ex || (nv && src[2]) || nxt[1:0] != 2'b00) begin
               m_addr = EXC; m_epc = m_ipc; m_pulse = 1;
            end else begin
               m_addr = nxt;
            end
         end
      end else if (m_discard) begin
         if (ak) begin
            m_discard = 0; m_addr = EXC;
         end
      end else if (m_req) begin
         if (ak && ex) begin
            m_epc = m_addr; m_pulse = 1; m_addr = EXC;
         end else if (ak) begin
            m_hold = 1; m_req = 0; m_instr = rd; m_ipc = m_addr;
         end else if (ex) begin
            m_epc = m_addr; m_pulse = 1; m_discard = 1;
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 0", if_instr); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_ifpc: got %h exp 0", if_pc); end
      checks++; if (exc_taken !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b exp 0", exc_taken); end
      checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h exp 0", epc); end
      rst_n = 1;
   endtask

   // Ack held high: fetch 3000, 3004, 3008 with if_valid alternating
   task automatic test_seq_fetch();
      imem_ack = 1;
      for (int i = 0; i < 6; i++) begin
         imem_rdata = 32'hA000_0000 + 32'(i);
         tick();
         checks++; if (if_valid !== 1'(i % 2)) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp %b", i, if_valid, 1'(i % 2)); end
         if (i % 2 == 0) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC + 32'(4 * (i / 2)))
               begin errors++; $display("FAIL seq_addr[%0d]: got req %b addr %h exp %h", i, imem_req, imem_addr, RST_PC + 32'(4 * (i / 2))); end
         end else begin
            checks++; if (if_pc !== RST_PC + 32'(4 * (i / 2)) || if_instr !== 32'hA000_0000 + 32'(i) || imem_req !== 1'b0)
               begin errors++; $display("FAIL seq_instr[%0d]: got pc %h instr %h req %b", i, if_pc, if_instr, imem_req); end
         end
      end
      imem_ack = 0;
   endtask

   task automatic test_branch();
      npc_valid = 1; npc_src = 3'b001; npc = 32'h0000_3040;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3040 || exc_taken !== 1'b0)
         begin errors++; $display("FAIL branch_addr: got req %b addr %h exc %b exp 3040", imem_req, imem_addr, exc_taken); end
      npc_valid = 0; imem_ack = 1; imem_rdata = 32'h1234_5678;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3040)
         begin errors++; $display("FAIL branch_ifpc: got valid %b pc %h exp 3040", if_valid, if_pc); end
      imem_ack = 0;
   endtask

   task automatic test_stall();
      logic [31:0] held_instr;
      held_instr = if_instr;
      stall = 1; npc_src = 3'b010; npc = 32'h0000_5000;
      for (int k = 0; k < 3; k++) begin
         npc_valid = (k % 2 == 0);
         tick();
         checks++; if (if_valid !== 1'b1 || if_instr !== held_instr || if_pc !== 32'h0000_3040 || imem_req !== 1'b0)
            begin errors++; $display("FAIL stall_hold[%0d]: got valid %b instr %h pc %h req %b", k, if_valid, if_instr, if_pc, imem_req); end
      end
      stall = 0; npc_valid = 0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3044 || if_valid !== 1'b0)
         begin errors++; $display("FAIL stall_next: got req %b addr %h valid %b exp 3044", imem_req, imem_addr, if_valid); end
   endtask

   task automatic test_exc_fetch();
      do_reset();
      imem_ack = 1;
      repeat (4) tick();
      imem_ack = 0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008)
         begin errors++; $display("FAIL excf_pre: got req %b addr %h exp 3008", imem_req, imem_addr); end
      exc_req = 1;
      tick();
      checks++; if (exc_taken !== 1'b1 || epc !== 32'h0000_3008 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3008)
         begin errors++; $display("FAIL excf_take: got exc %b epc %h req %b addr %h", exc_taken, epc, imem_req, imem_addr); end
      tick();
      checks++; if (exc_taken !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3008 || if_valid !== 1'b0)
         begin errors++; $display("FAIL excf_drain: got exc %b req %b addr %h valid %b", exc_taken, imem_req, imem_addr, if_valid); end
      exc_req = 0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== EXC || if_valid !== 1'b0 || exc_taken !== 1'b0)
         begin errors++; $display("FAIL excf_vec: got req %b addr %h valid %b exc %b", imem_req, imem_addr, if_valid, exc_taken); end
      imem_rdata = 32'h0000_0C0D;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== EXC || if_instr !== 32'h0000_0C0D)
         begin errors++; $display("FAIL excf_instr: got valid %b pc %h instr %h", if_valid, if_pc, if_instr); end
      imem_ack = 0;
   endtask

   task automatic test_misaligned();
      npc_valid = 1; npc_src = 3'b011; npc = 32'h0000_3002;
      tick();
      checks++; if (exc_taken !== 1'b1 || epc !== EXC || imem_addr !== EXC || imem_req !== 1'b1 || if_valid !== 1'b0)
         begin errors++; $display("FAIL misal_take: got exc %b epc %h addr %h req %b", exc_taken, epc, imem_addr, imem_req); end
      npc_valid = 0;
      tick();
      checks++; if (exc_taken !== 1'b0)
         begin errors++; $display("FAIL misal_pulse: got exc %b exp 0", exc_taken); end
   endtask

   task automatic test_wrap();
      imem_ack = 1;
      tick();
      imem_ack = 0; npc_valid = 1; npc_src = 3'b010; npc = 32'hFFFF_FFFC;
      tick();
      checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1)
         begin errors++; $display("FAIL wrap_jump: got addr %h req %b", imem_addr, imem_req); end
      npc_valid = 0; imem_ack = 1;
      tick();
      imem_ack = 0;
      tick();
      checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || exc_taken !== 1'b0)
         begin errors++; $display("FAIL wrap_seq: got addr %h req %b exc %b exp 0", imem_addr, imem_req, exc_taken); end
   endtask

   task automatic test_reset_mid_fetch();
      checks++; if (imem_req !== 1'b1)
         begin errors++; $display("FAIL rstmid_pre: got req %b exp 1", imem_req); end
      #2 rst_n = 0;
      imem_ack = 1;
      #1;
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0)
         begin errors++; $display("FAIL rstmid_drop: got req %b valid %b", imem_req, if_valid); end
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC)
         begin errors++; $display("FAIL rstmid_boot: got valid %b req %b addr %h", if_valid, imem_req, imem_addr); end
      imem_rdata = 32'h5555_AAAA;
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC)
         begin errors++; $display("FAIL rstmid_first: got valid %b pc %h", if_valid, if_pc); end
      imem_ack = 0;
   endtask

   task automatic test_random();
      logic [31:0] r;
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         stall     = ($urandom % 10) < 3;
         npc_valid = ($urandom % 2) == 0;
         npc_src   = (($urandom % 10) == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
         r = $urandom;
         case ($urandom % 8)
            0:       npc = 32'hFFFF_FFFC;
            1:       npc = (r & ~32'h3) | 32'(1 + $urandom % 3);
            default: npc = r & ~32'h3;
         endcase
         exc_req    = ($urandom % 20) == 0;
         imem_ack   = m_req && (($urandom % 2) == 0);
         imem_rdata = $urandom;
         model_step(stall, npc_valid, npc_src, npc, exc_req, imem_ack, imem_rdata);
         tick();
         checks++; if (imem_req !== m_req)
            begin errors++; $display("FAIL rnd_req[%0d]: got %b exp %b", c, imem_req, m_req); end
         if (m_req) begin
            checks++; if (imem_addr !== m_addr)
               begin errors++; $display("FAIL rnd_addr[%0d]: got %h exp %h", c, imem_addr, m_addr); end
         end
         checks++; if (if_valid !== m_hold)
            begin errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", c, if_valid, m_hold); end
         checks++; if (if_instr !== m_instr || if_pc !== m_ipc)
            begin errors++; $display("FAIL rnd_if[%0d]: got %h/%h exp %h/%h", c, if_instr, if_pc, m_instr, m_ipc); end
         checks++; if (exc_taken !== m_pulse || epc !== m_epc)
            begin errors++; $display("FAIL rnd_exc[%0d]: got %b/%h exp %b/%h", c, exc_taken, epc, m_pulse, m_epc); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_branch();
      test_stall();
      test_exc_fetch();
      test_misaligned();
      test_wrap();
      test_reset_mid_fetch();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
